// File: rtl/matrix_capture.sv
// Rebuilds the 16x16 LED matrix row/column shift registers from sampled pins and stores each latched pattern in a Wishbone-readable frame buffer.
// Optional MATRIX_CAPTURE_SYNC_EN: 2-flop pin synchronizers (pin-to-event latency 2 clocks) instead of a single sample flop (latency 1).
module matrix_capture #(
    parameter int ROWS = 16,
    parameter int COLS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        rclk,
    input  logic        rsdi,
    input  logic        cclk,
    input  logic        csdi,
    input  logic        le,
    input  logic        oeb,
    output logic        frame_strobe
);
    // Pin vector order: 0 rclk, 1 rsdi, 2 cclk, 3 csdi, 4 le, 5 oeb
    logic [5:0] pins;
    logic [5:0] sync_q;
    logic [5:0] prev_q;

    assign pins = {oeb, le, csdi, cclk, rsdi, rclk};

`ifdef MATRIX_CAPTURE_SYNC_EN
    logic [5:0] meta_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= pins;
            sync_q <= meta_q;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= pins;
        end
    end
`endif

    logic rclk_ev, cclk_ev, le_ev;

    assign rclk_ev = sync_q[0] & ~prev_q[0];
    assign cclk_ev = sync_q[2] & ~prev_q[2];
    assign le_ev   = sync_q[4] & ~prev_q[4];

    logic [ROWS-1:0] row_sr_q, row_sr_d, row_lat_q, row_lat_d;
    logic [COLS-1:0] col_sr_q, col_sr_d, col_lat_q, col_lat_d;
    logic [COLS-1:0] frame_q [ROWS];
    logic [COLS-1:0] frame_d [ROWS];
    logic [31:0]     cnt_q, cnt_d;
    logic            wr_pend_q, wr_pend_d;
    logic            strobe_q, strobe_d;
    logic            ack_q, ack_d;
    logic [31:0]     dat_q, dat_d;

    logic [4:0]  word;
    logic        wb_req;
    logic        clr;
    logic [31:0] rd_data;

    assign word   = wbs_adr_i[6:2];
    assign wb_req = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign clr    = wb_req & wbs_we_i & (word == 5'd18) & wbs_dat_i[0];

    always_comb begin
        rd_data = '0;
        if (!word[4]) begin
            rd_data = {{(32-COLS){1'b0}}, frame_q[word[3:0]]};
        end else if (word == 5'd16) begin
            rd_data = cnt_q;
        end else if (word == 5'd17) begin
            rd_data = {{(31-ROWS){1'b0}}, sync_q[5], row_lat_q};
        end
    end

    always_comb begin
        row_sr_d  = rclk_ev ? {row_sr_q[ROWS-2:0], sync_q[1]} : row_sr_q;
        col_sr_d  = cclk_ev ? {col_sr_q[COLS-2:0], sync_q[3]} : col_sr_q;
        // Latch uses the registered (pre-shift) values when shift and LE coincide
        row_lat_d = le_ev ? row_sr_q : row_lat_q;
        col_lat_d = le_ev ? col_sr_q : col_lat_q;
        wr_pend_d = le_ev;
        strobe_d  = wr_pend_q;
        frame_d   = frame_q;
        cnt_d     = cnt_q;
        if (wr_pend_q) begin
            cnt_d = cnt_q + 32'd1;
            for (int i = 0; i < ROWS; i++) begin
                if (row_lat_q[i]) frame_d[i] = col_lat_q;
            end
        end
        if (clr) begin
            cnt_d = '0;
            for (int i = 0; i < ROWS; i++) frame_d[i] = '0;
        end
        ack_d = wb_req;
        dat_d = wb_req ? rd_data : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q    <= '0;
            row_sr_q  <= '0;
            col_sr_q  <= '0;
            row_lat_q <= '0;
            col_lat_q <= '0;
            cnt_q     <= '0;
            wr_pend_q <= 1'b0;
            strobe_q  <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            for (int i = 0; i < ROWS; i++) frame_q[i] <= '0;
        end else begin
            prev_q    <= sync_q;
            row_sr_q  <= row_sr_d;
            col_sr_q  <= col_sr_d;
            row_lat_q <= row_lat_d;
            col_lat_q <= col_lat_d;
            cnt_q     <= cnt_d;
            wr_pend_q <= wr_pend_d;
            strobe_q  <= strobe_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            for (int i = 0; i < ROWS; i++) frame_q[i] <= frame_d[i];
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign frame_strobe = strobe_q;

    logic unused_ok;
    assign unused_ok = ^{wbs_adr_i[31:7], wbs_adr_i[1:0], wbs_dat_i[31:1]};

endmodule

// File: tb/tb_matrix_capture.sv
// Randomized bench for matrix_capture: drives matrix pins at a slow rate and checks the Wishbone view against a frame-level model.
module tb_matrix_capture;
`ifdef MATRIX_CAPTURE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        rclk = 1'b0, rsdi = 1'b0, cclk = 1'b0, csdi = 1'b0, le = 1'b0, oeb = 1'b0;
    logic        frame_strobe;

    int checks = 0;
    int errors = 0;

    // Frame-level reference state
    logic [15:0] m_row, m_col, m_lat_row;
    logic [15:0] m_frame [16];
    logic [31:0] m_cnt;
    logic        m_oeb;

    matrix_capture #(.ROWS(16), .COLS(16)) dut (
        .clk(clk), .reset(reset),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .rclk(rclk), .rsdi(rsdi), .cclk(cclk), .csdi(csdi), .le(le), .oeb(oeb),
        .frame_strobe(frame_strobe)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_row = '0; m_col = '0; m_lat_row = '0; m_cnt = '0;
        for (int i = 0; i < 16; i++) m_frame[i] = '0;
    endtask

    task automatic model_latch();
        m_lat_row = m_row;
        for (int i = 0; i < 16; i++) if (m_lat_row[i]) m_frame[i] = m_col;
        m_cnt = m_cnt + 1;
    endtask

    task automatic wb_access(input logic we, input int w, input logic [31:0] wdat, output logic [31:0] rdat);
        int n;
        bit got;
        @(negedge clk);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = 32'(w) << 2; wbs_dat_i = wdat;
        got = 0; n = 0; rdat = '0;
        while (!got && n < 4) begin
            @(posedge clk); #1;
            n++;
            if (wbs_ack_o) begin
                got = 1;
                rdat = wbs_dat_o;
            end
        end
        check("ack_latency", 32'(n), 32'd1);
        @(negedge clk);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wb_read(input int w, output logic [31:0] rdat);
        wb_access(1'b0, w, 32'd0, rdat);
    endtask

    task automatic wb_write(input int w, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_access(1'b1, w, wdat, dummy);
    endtask

    task automatic check_all();
        logic [31:0] d;
        for (int w = 0; w < 16; w++) begin
            wb_read(w, d);
            check($sformatf("frame%0d", w), d, {16'h0, m_frame[w]});
        end
        wb_read(16, d);
        check("frame_cnt", d, m_cnt);
        wb_read(17, d);
        check("status", d, {15'h0, m_oeb, m_lat_row});
    endtask

    // Shifts 16 bits MSB first on both row and column lines
    task automatic shift_bits(input logic [15:0] r, input logic [15:0] c);
        for (int b = 15; b >= 0; b--) begin
            @(negedge clk);
            rsdi = r[b]; csdi = c[b]; rclk = 1'b0; cclk = 1'b0;
            repeat (2) @(negedge clk);
            rclk = 1'b1; cclk = 1'b1;
            m_row = {m_row[14:0], r[b]};
            m_col = {m_col[14:0], c[b]};
            repeat (2) @(negedge clk);
            rclk = 1'b0; cclk = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_le();
        @(negedge clk);
        le = 1'b1;
        model_latch();
        repeat (2) @(negedge clk);
        le = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d, d2;
        logic [15:0] r, c;
        int first, pulses;

        model_reset();
        m_oeb = 1'b0;
        #1;
        check("rst_ack", {31'b0, wbs_ack_o}, 32'd0);
        check("rst_strobe", {31'b0, frame_strobe}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        wb_read(16, d);
        check("rst_cnt", d, 32'd0);

        // Single row with strobe timing
        shift_bits(16'h0001, 16'hA5C3);
        @(negedge clk);
        le = 1'b1;
        model_latch();
        first = 0; pulses = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (frame_strobe) begin
                pulses++;
                if (first == 0) first = n;
            end
        end
        @(negedge clk);
        le = 1'b0;
        check("strobe_edge", 32'(first), 32'(LAT + 2));
        check("strobe_count", 32'(pulses), 32'd1);
        wb_read(0, d);
        check("single_row0", d, 32'h0000A5C3);
        wb_read(16, d);
        check("single_cnt", d, 32'd1);

        // Asynchronous reset while a read is being acknowledged
        @(negedge clk);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'd16 << 2;
        @(posedge clk); #1;
        check("pre_rst_ack", {31'b0, wbs_ack_o}, 32'd1);
        check("pre_rst_dat", wbs_dat_o, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_ack", {31'b0, wbs_ack_o}, 32'd0);
        check("async_dat", wbs_dat_o, 32'd0);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        wb_read(16, d);
        check("post_rst_cnt", d, 32'd0);
        wb_read(0, d);
        check("post_rst_row0", d, 32'd0);

        // Full frame scan
        for (int i = 0; i < 16; i++) begin
            shift_bits(16'h1 << i, 16'(16'h1111 * i));
            pulse_le();
        end
        check_all();

        // Multi-row then zero-row latch
        shift_bits(16'h8001, 16'hFFFF);
        pulse_le();
        check_all();
        shift_bits(16'h0000, 16'h1234);
        pulse_le();
        check_all();

        // CCLK and LE in the same cycle: latch holds pre-shift column
        shift_bits(16'h0004, 16'h3C5A);
        @(negedge clk);
        csdi = 1'b1; cclk = 1'b1; le = 1'b1;
        model_latch();
        m_col = {m_col[14:0], 1'b1};
        repeat (2) @(negedge clk);
        cclk = 1'b0; le = 1'b0;
        repeat (4) @(negedge clk);
        wb_read(2, d);
        check("same_cycle_pre", d, 32'h00003C5A);
        pulse_le();
        wb_read(2, d);
        check("same_cycle_post", d, {16'h0, m_frame[2]});

        // Random frames
        for (int it = 0; it < 12; it++) begin
            @(negedge clk);
            oeb = 1'($urandom % 2);
            m_oeb = oeb;
            case ($urandom % 4)
                0: r = 16'h0;
                1: r = 16'h1 << ($urandom % 16);
                default: r = 16'($urandom);
            endcase
            c = 16'($urandom);
            shift_bits(r, c);
            pulse_le();
            check_all();
        end

        // Control clear landing on the frame write edge
        shift_bits(16'hF0F0, 16'hBEEF);
        @(negedge clk);
        le = 1'b1;
        model_latch();
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'd18 << 2; wbs_dat_i = 32'd1;
        @(posedge clk); #1;
        check("clr_ack", {31'b0, wbs_ack_o}, 32'd1);
        check("clr_strobe", {31'b0, frame_strobe}, 32'd1);
        @(negedge clk);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        le = 1'b0;
        for (int i = 0; i < 16; i++) m_frame[i] = '0;
        m_cnt = '0;
        repeat (4) @(negedge clk);
        check_all();

        // Wishbone corner cases
        shift_bits(16'h0020, 16'h5A5A);
        pulse_le();
        wb_read(20, d);
        check("unmapped", d, 32'd0);
        wb_read(18, d);
        check("ctrl_read", d, 32'd0);
        wb_write(5, 32'hFFFF_FFFF);
        wb_write(16, 32'h0000_00AA);
        wb_read(5, d);
        check("ro_frame5", d, {16'h0, m_frame[5]});
        wb_read(16, d);
        check("ro_cnt", d, m_cnt);
        wb_write(18, 32'd0);
        wb_read(16, d);
        check("ctrl_bit0_zero", d, m_cnt);

        // Back-to-back reads with strobe held
        @(negedge clk);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'd16 << 2;
        @(posedge clk); #1;
        check("b2b_ack1", {31'b0, wbs_ack_o}, 32'd1);
        d = wbs_dat_o;
        @(negedge clk);
        wbs_adr_i = 32'd17 << 2;
        @(posedge clk); #1;
        check("b2b_gap", {31'b0, wbs_ack_o}, 32'd0);
        check("b2b_gap_dat", wbs_dat_o, 32'd0);
        @(posedge clk); #1;
        check("b2b_ack2", {31'b0, wbs_ack_o}, 32'd1);
        d2 = wbs_dat_o;
        @(negedge clk);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        @(posedge clk); #1;
        check("b2b_end", {31'b0, wbs_ack_o}, 32'd0);
        check("b2b_dat1", d, m_cnt);
        check("b2b_dat2", d2, {15'h0, m_oeb, m_lat_row});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
